// File: rtl/wb_arbiter.sv
`timescale 1ns/1ps
// wb_arbiter: multi-channel writeback stage. Per-channel FIFOs feed a round-robin arbiter onto the single register-file write port.
// Optional feature: define WB_RETIRE_CNT_EN to add the 64-bit retire_count output.
module wb_arbiter #(
  parameter int NUM_CH = 2,
  parameter int XLEN   = 32,
  parameter int RAW    = 5,
  parameter int EXW    = 4,
  parameter int DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         ch_valid,
  output logic [NUM_CH-1:0]         ch_ready,
  input  logic [NUM_CH-1:0]         ch_wen,
  input  logic [NUM_CH*RAW-1:0]     ch_rd,
  input  logic [NUM_CH*XLEN-1:0]    ch_data,
  input  logic [NUM_CH-1:0]         ch_exc_valid,
  input  logic [NUM_CH*EXW-1:0]     ch_exc,
  input  logic [NUM_CH-1:0]         ch_halt,
  input  logic                      exc_clear,
  output logic [RAW-1:0]            wr_addr,
  output logic [XLEN-1:0]           wr_data,
  output logic                      wr_enable,
  output logic                      exc_valid_out,
  output logic [EXW-1:0]            exc_cause_out,
  output logic [$clog2(NUM_CH)-1:0] exc_ch_out,
  output logic                      halt_out
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]               retire_count
`endif
);

  localparam int CW = $clog2(NUM_CH);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic            wen;
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] data;
    logic            exc_valid;
    logic [EXW-1:0]  exc;
    logic            halt;
  } entry_t;

  entry_t            mem  [NUM_CH][DEPTH];
  logic [PW-1:0]     wptr [NUM_CH];
  logic [PW-1:0]     rptr [NUM_CH];
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [CW-1:0]     last_grant;
  logic [CW-1:0]     grant;
  logic              pop;
  entry_t            head;

  // The extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      empty[i] = (wptr[i] == rptr[i]);
      full[i]  = (wptr[i][AW] != rptr[i][AW]) && (wptr[i][AW-1:0] == rptr[i][AW-1:0]);
    end
  end

  assign ch_ready = ~full;
  assign push     = ch_valid & ~full;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    grant = last_grant;
    pop   = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!pop && (i == (int'(last_grant) + k) % NUM_CH) && !empty[i]) begin
          grant = CW'(i);
          pop   = 1'b1;
        end
      end
    end
    // Exception or halt freezes the arbiter; entries stay buffered.
    if (halt_out || exc_valid_out) pop = 1'b0;
  end

  assign head = mem[grant][rptr[grant][AW-1:0]];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + PW'(1);
        if (pop && (grant == CW'(i))) rptr[i] <= rptr[i] + PW'(1);
      end
    end
  end

  // NOTE: entry storage is deliberately not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        mem[i][wptr[i][AW-1:0]] <= '{wen:       ch_wen[i],
                                     rd:        ch_rd[i*RAW +: RAW],
                                     data:      ch_data[i*XLEN +: XLEN],
                                     exc_valid: ch_exc_valid[i],
                                     exc:       ch_exc[i*EXW +: EXW],
                                     halt:      ch_halt[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant    <= CW'(NUM_CH - 1);
      wr_enable     <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      exc_valid_out <= 1'b0;
      exc_cause_out <= '0;
      exc_ch_out    <= '0;
      halt_out      <= 1'b0;
    end else begin
      wr_enable <= 1'b0;
      if (exc_clear) exc_valid_out <= 1'b0;
      if (pop) begin
        last_grant <= grant;
        if (head.exc_valid) begin
          exc_valid_out <= 1'b1;
          exc_cause_out <= head.exc;
          exc_ch_out    <= grant;
        end else if (head.halt) begin
          halt_out <= 1'b1;
        end else if (head.wen && (head.rd != '0)) begin
          wr_enable <= 1'b1;
          wr_addr   <= head.rd;
          wr_data   <= head.data;
        end
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) retire_count <= '0;
    else if (pop && !head.exc_valid && !head.halt) retire_count <= retire_count + 64'd1;
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
`timescale 1ns/1ps
// Testbench for wb_arbiter: queue-based reference model compared every cycle, plus directed literal checks.
module tb_wb_arbiter;

  localparam int NCH   = 2;
  localparam int XLEN  = 32;
  localparam int RAW   = 5;
  localparam int EXW   = 4;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic            wen;
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] data;
    logic            exc_v;
    logic [EXW-1:0]  exc;
    logic            halt;
  } tb_ent_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NCH-1:0]         ch_valid, ch_ready, ch_wen, ch_exc_valid, ch_halt;
  logic [NCH*RAW-1:0]     ch_rd;
  logic [NCH*XLEN-1:0]    ch_data;
  logic [NCH*EXW-1:0]     ch_exc;
  logic                   exc_clear;
  logic [RAW-1:0]         wr_addr;
  logic [XLEN-1:0]        wr_data;
  logic                   wr_enable, exc_valid_out, halt_out;
  logic [EXW-1:0]         exc_cause_out;
  logic [$clog2(NCH)-1:0] exc_ch_out;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0]            retire_count;
`endif

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.NUM_CH(NCH), .XLEN(XLEN), .RAW(RAW), .EXW(EXW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_wen(ch_wen), .ch_rd(ch_rd), .ch_data(ch_data),
    .ch_exc_valid(ch_exc_valid), .ch_exc(ch_exc), .ch_halt(ch_halt), .exc_clear(exc_clear),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .exc_valid_out(exc_valid_out), .exc_cause_out(exc_cause_out), .exc_ch_out(exc_ch_out),
    .halt_out(halt_out)
`ifdef WB_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-channel queues, round-robin pointer and flags, updated per clock edge.
  tb_ent_t         mq [NCH][$];
  int              m_lg;
  logic            m_wen, m_exc, m_halt;
  logic [RAW-1:0]  m_addr;
  logic [XLEN-1:0] m_data;
  logic [EXW-1:0]  m_cause;
  int              m_ch;
  logic [63:0]     m_ret;
  logic            started = 1'b0;
  tb_ent_t         m_e;
  int              m_found;
  logic [NCH-1:0]  m_acc;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) mq[i].delete();
      m_lg = NCH - 1; m_wen = 0; m_addr = 0; m_data = 0;
      m_exc = 0; m_cause = 0; m_ch = 0; m_halt = 0; m_ret = 0;
      started = 1'b1;
    end else begin
      for (int i = 0; i < NCH; i++) m_acc[i] = ch_valid[i] && (mq[i].size() < DEPTH);
      m_found = -1;
      if (!m_exc && !m_halt) begin
        for (int k = 1; k <= NCH; k++) begin
          if (m_found < 0 && mq[(m_lg + k) % NCH].size() > 0) m_found = (m_lg + k) % NCH;
        end
      end
      m_wen = 0;
      if (exc_clear) m_exc = 0;
      if (m_found >= 0) begin
        m_e  = mq[m_found].pop_front();
        m_lg = m_found;
        if (m_e.exc_v) begin
          m_exc = 1; m_cause = m_e.exc; m_ch = m_found;
        end else if (m_e.halt) begin
          m_halt = 1;
        end else begin
          m_ret = m_ret + 1;
          if (m_e.wen && m_e.rd != 0) begin
            m_wen = 1; m_addr = m_e.rd; m_data = m_e.data;
          end
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (m_acc[i]) mq[i].push_back('{wen: ch_wen[i], rd: ch_rd[i*RAW +: RAW],
                                        data: ch_data[i*XLEN +: XLEN], exc_v: ch_exc_valid[i],
                                        exc: ch_exc[i*EXW +: EXW], halt: ch_halt[i]});
      end
    end
  end

  logic [NCH-1:0] exp_ready;
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < NCH; i++) exp_ready[i] = (mq[i].size() < DEPTH);
      check("wr_enable", 64'(wr_enable), 64'(m_wen));
      if (m_wen) begin
        check("wr_addr", 64'(wr_addr), 64'(m_addr));
        check("wr_data", 64'(wr_data), 64'(m_data));
      end
      check("ch_ready", 64'(ch_ready), 64'(exp_ready));
      check("exc_valid_out", 64'(exc_valid_out), 64'(m_exc));
      check("exc_cause_out", 64'(exc_cause_out), 64'(m_cause));
      check("exc_ch_out", 64'(exc_ch_out), 64'(m_ch));
      check("halt_out", 64'(halt_out), 64'(m_halt));
`ifdef WB_RETIRE_CNT_EN
      check("retire_count", retire_count, m_ret);
`endif
    end
  end

  task automatic clr();
    ch_valid = '0; ch_wen = '0; ch_rd = '0; ch_data = '0;
    ch_exc_valid = '0; ch_exc = '0; ch_halt = '0; exc_clear = 1'b0;
  endtask

  task automatic set_ch(input int c, input logic wen, input logic [RAW-1:0] rd,
                        input logic [XLEN-1:0] data, input logic ev, input logic [EXW-1:0] ex,
                        input logic h);
    ch_valid[c] = 1'b1; ch_wen[c] = wen; ch_rd[c*RAW +: RAW] = rd;
    ch_data[c*XLEN +: XLEN] = data; ch_exc_valid[c] = ev; ch_exc[c*EXW +: EXW] = ex;
    ch_halt[c] = h;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    clr();
    reset = 1'b1;
    tick(2);
    check("reset ch_ready", 64'(ch_ready), 64'(2'b11));
    check("reset wr_enable", 64'(wr_enable), 64'd0);
    check("reset halt/exc", 64'({halt_out, exc_valid_out}), 64'd0);
    reset = 1'b0;

    // Single write: accepted at the first edge, visible for exactly one cycle after the second.
    set_ch(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    tick(1); clr();
    check("single early", 64'(wr_enable), 64'd0);
    tick(1);
    check("single wen/addr", 64'({wr_enable, wr_addr}), 64'({1'b1, 5'd5}));
    check("single data", 64'(wr_data), 64'h0000_0000_DEAD_BEEF);
    tick(1);
    check("single pulse", 64'(wr_enable), 64'd0);

    // Round-robin from a fresh reset: ch0 has first priority.
    reset = 1'b1; tick(1); reset = 1'b0;
    set_ch(0, 1, 5'd1, 32'h100, 0, 0, 0); set_ch(1, 1, 5'd3, 32'h200, 0, 0, 0);
    tick(1);
    set_ch(0, 1, 5'd2, 32'h101, 0, 0, 0); set_ch(1, 1, 5'd4, 32'h201, 0, 0, 0);
    tick(1); clr();
    check("rr 1st", 64'({wr_enable, wr_addr}), 64'({1'b1, 5'd1}));
    tick(1);
    check("rr 2nd", 64'({wr_enable, wr_addr}), 64'({1'b1, 5'd3}));
    tick(1);
    check("rr 3rd", 64'({wr_enable, wr_addr}), 64'({1'b1, 5'd2}));
    tick(1);
    check("rr 4th", 64'({wr_enable, wr_addr}), 64'({1'b1, 5'd4}));
    check("rr 4th data", 64'(wr_data), 64'h201);
    tick(1);

    // rd = 0 commits without a write.
    set_ch(0, 1, 5'd0, 32'h1234, 0, 0, 0);
    tick(1); clr();
    tick(1);
    check("x0 no write", 64'(wr_enable), 64'd0);
    tick(1);

    // Exception on ch1, later ch0 exception buffered, ch1 back-pressure while frozen.
    set_ch(1, 0, 5'd0, 32'h0, 1, 4'h3, 0);
    tick(1); clr();
    tick(1);
    check("exc1 latched", 64'({exc_valid_out, exc_cause_out, exc_ch_out}), 64'({1'b1, 4'h3, 1'b1}));
    set_ch(0, 0, 5'd0, 32'h0, 1, 4'h7, 0);
    set_ch(1, 1, 5'd9, 32'h900, 0, 0, 0);
    tick(1); clr();
    set_ch(1, 1, 5'd10, 32'hA00, 0, 0, 0);
    tick(1); clr();
    check("ch1 full", 64'(ch_ready), 64'(2'b01));
    set_ch(1, 1, 5'd11, 32'hB00, 0, 0, 0);
    tick(1); clr();
    check("ch1 still full", 64'(ch_ready), 64'(2'b01));
    exc_clear = 1'b1;
    tick(1); exc_clear = 1'b0;
    check("exc cleared", 64'({exc_valid_out, exc_cause_out}), 64'({1'b0, 4'h3}));
    tick(1);
    check("exc0 latched", 64'({exc_valid_out, exc_cause_out, exc_ch_out}), 64'({1'b1, 4'h7, 1'b0}));
    exc_clear = 1'b1;
    tick(1); exc_clear = 1'b0;
    tick(1);
    check("drain rd9", 64'({wr_enable, wr_addr}), 64'({1'b1, 5'd9}));
    tick(1);
    check("drain rd10", 64'({wr_enable, wr_addr}), 64'({1'b1, 5'd10}));
    tick(1);
    check("rd11 dropped", 64'(wr_enable), 64'd0);

    // Halt followed by writes on the same channel: nothing is written, FIFO fills.
    set_ch(0, 0, 5'd0, 32'h0, 0, 0, 1);
    tick(1); clr();
    tick(1);
    check("halt set", 64'(halt_out), 64'd1);
    set_ch(0, 1, 5'd12, 32'hC00, 0, 0, 0);
    tick(1); clr();
    set_ch(0, 1, 5'd13, 32'hD00, 0, 0, 0);
    tick(1); clr();
    check("halt backpressure", 64'(ch_ready), 64'(2'b10));
    tick(2);
    check("halt no write", 64'(wr_enable), 64'd0);

    // Reset mid-stream with two entries buffered.
    reset = 1'b1;
    tick(1);
    check("mid reset flags", 64'({halt_out, exc_valid_out, exc_cause_out, wr_enable}), 64'd0);
    check("mid reset ready", 64'(ch_ready), 64'(2'b11));
    reset = 1'b0;
    tick(3);
    check("no stale write", 64'(wr_enable), 64'd0);

    // Sustained traffic on both channels, including rd = 0 and pushes against a full FIFO.
    for (int cyc = 0; cyc < 40; cyc++) begin
      clr();
      for (int c = 0; c < NCH; c++) begin
        if ((cyc + c) % 3 != 2)
          set_ch(c, logic'(cyc % 5 != 4), RAW'((cyc * 3 + c) % 8), XLEN'(cyc * 16 + c), 0, 0, 0);
      end
      tick(1);
    end
    clr();
    tick(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Parametrised multi-channel writeback stage. It accepts completed results from NUM_CH execution channels (e.g. ALU, load unit) through per-channel valid/ready FIFOs and arbitrates them round-robin onto the single register-file write port. It latches the first exception and a sticky halt. It sits between the execute/memory channels and the register file, replacing the single-channel writeback.

## Interface
Parameters:
- NUM_CH, 2: number of input channels (≥2).
- XLEN, 32: result data width.
- RAW, 5: register address width.
- EXW, 4: exception cause width.
- DEPTH, 2: per-channel FIFO depth (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- ch_valid  in  NUM_CH  per-channel entry valid.
- ch_ready  out  NUM_CH  per-channel FIFO not full.
- ch_wen  in  NUM_CH  entry writes rd.
- ch_rd  in  NUM_CH*RAW  destination register; channel i at [i*RAW +: RAW].
- ch_data  in  NUM_CH*XLEN  result, packed as for ch_rd.
- ch_exc_valid  in  NUM_CH  entry carries an exception.
- ch_exc  in  NUM_CH*EXW  exception cause.
- ch_halt  in  NUM_CH  entry is a halt marker.
- exc_clear  in  1  acknowledge and clear the latched exception.
- wr_addr  out  RAW  register-file write address (registered).
- wr_data  out  XLEN  register-file write data (registered).
- wr_enable  out  1  register-file write strobe (registered).
- exc_valid_out  out  1  exception latched.
- exc_cause_out  out  EXW  latched cause.
- exc_ch_out  out  clog2(NUM_CH)  channel that raised it.
- halt_out  out  1  sticky halt.
- retire_count  out  64  committed-entry count (present only with WB_RETIRE_CNT_EN).

## Operation
- Push: channel i accepts when ch_valid[i] && ch_ready[i]. ch_ready[i] = !full[i], evaluated from state at the start of the cycle. A full FIFO does not accept in a cycle in which it is popped.
- Arbitration: each cycle at most one non-empty FIFO is popped. Search starts at last_grant+1 mod NUM_CH. last_grant resets to NUM_CH-1, so channel 0 has first priority.
- No pops occur while halt_out=1 or exc_valid_out=1 (see below).
- Popped entry handling, in priority order:
  - Exception: if exc_valid_out=0, latch cause and channel and set exc_valid_out. No write.
  - Halt: set halt_out. No write.
  - ch_wen=1 and rd≠0: next cycle wr_enable=1 with wr_addr=rd and wr_data=data.
  - Otherwise (rd=0 or wen=0): commit with no write.
- Exception freeze: while exc_valid_out=1, the arbiter stops popping and entries are held in the FIFOs.
  - exc_clear=1 clears exc_valid_out at the next edge. Popping resumes the cycle after.
  - exc_cause_out and exc_ch_out hold their last value until the next exception.
- halt_out is sticky until reset. FIFOs back-pressure once full.
- Reset: all FIFOs empty and last_grant=NUM_CH-1. All outputs are 0: ch_ready=all-ones once out of reset, wr_enable, wr_addr, wr_data, exc_valid_out, exc_cause_out, exc_ch_out, halt_out, retire_count. Reset mid-operation discards all buffered entries. A write registered in the reset cycle is not emitted.

## Timing
- Latency, uncontended: entry accepted at edge t, eligible in cycle t+1, popped at edge t+1, wr_enable high during cycle t+2. Exception and halt flags rise at the same edge as the pop (visible in cycle t+2).
- Throughput: one commit per cycle aggregate. Each channel gets at least 1 grant per NUM_CH cycles when all channels are busy.
- wr_enable is a single-cycle pulse per committed write. Back-to-back writes are allowed every cycle.
- FIFO pointers wrap mod DEPTH. Full/empty are distinguished with an extra pointer bit.

## Configuration
- WB_RETIRE_CNT_EN:
  - Defined: retire_count increments by 1 at each pop that commits a normal entry (write or no-write, including rd=0). It does not increment for exception or halt entries. It wraps at 2^64.
  - Undefined: the port and counter do not exist. All other behaviour is identical.

## Test plan
- Single write: ch0 push rd=5, data=0xDEADBEEF at edge 0 -> wr_enable=1, wr_addr=5, wr_data=0xDEADBEEF in cycle 2 only.
- Round-robin: NUM_CH=2, both channels push 2 entries each simultaneously -> commit order ch0,ch1,ch0,ch1 on 4 consecutive cycles.
- x0 and backpressure: push rd=0 -> no wr_enable (count +1 with macro). Fill ch1 to DEPTH while the pipe is stalled by an exception -> ch_ready[1]=0. The push with ch_ready low is ignored.
- Exception: ch1 entry with cause=0x3 -> exc_valid_out=1, exc_cause_out=3, exc_ch_out=1. A later queued ch0 exception (cause 7) stays buffered. exc_clear -> ch0 pops next and exc_cause_out=7.
- Halt: halt entry followed by a write entry on the same channel -> halt_out=1, the write is never emitted, and ch_ready drops after DEPTH more pushes.
- Reset mid-stream with 2 entries buffered -> all outputs 0 next cycle, no stale write afterwards.
